barcode_decoder: RTL and testbench
==================================

// Module: barcode_decoder
// PURPOSE
//  Decodes the self-clocked station barcode stream on BC (driven by the barcode_mimic
//  in the Follower bench) into an 8-bit station ID.
//  The start bit's low time sets the bit period. Each later bit is sampled one period
//  after its falling edge.
//  Feeds the Follower command/control logic, which compares ID against the commanded
//  destination.
// PARAMETERS
//  PER_W     22       width of period/sample counters (matches barcode_mimic period port)
//  TMO_MULT  4        WAIT_FALL timeout = TMO_MULT * measured period before abort
// PORTS
//  clk         in   1      system clock (50MHz)
//  rst_n       in   1      asynchronous active-low reset
//  BC          in   1      raw barcode serial input, idles high, asynchronous to clk
//  clr_ID_vld  in   1      one-cycle pulse from consumer, clears ID_vld
//  ID          out  8      last accepted station ID
//  ID_vld      out  1      high while ID holds an unconsumed valid station
//  busy        out  1      high while a frame is being received (any state but IDLE)
// BEHAVIOUR
//  Reset values: ID=8'h00, ID_vld=0, busy=0, state=IDLE, all counters/shift reg 0.
//  Reset asserted at any point, including mid-frame, returns to these values
//  immediately. The sync flops preset to 1.
//  Input conditioning:
//   - BC passes through two flops (BC_s) plus a third for edge detect.
//   - fall = prev & ~BC_s; rise = ~prev & BC_s.
//   - Pin-to-edge-pulse latency is 3 clk. All decisions use BC_s only.
//  Frame: one start bit (low), then 8 data bits, MSB first.
//   - Every bit begins with a falling edge.
//   - Data bit value = BC_s level sampled exactly `period` clocks after its falling edge.
//  States:
//   IDLE      : busy=0; on fall -> START with per_cnt=0.
//   START     : per_cnt++ each clk while BC_s low.
//               On rise -> period<=per_cnt, bit_cnt<=0, go to WAIT_FALL.
//               If per_cnt saturates at all-ones -> IDLE (abort, no output change).
//   WAIT_FALL : tmo_cnt++ each clk.
//               On fall -> SAMPLE with smp_cnt=0, tmo_cnt=0.
//               If tmo_cnt reaches TMO_MULT*period -> IDLE (abort).
//   SAMPLE    : smp_cnt++ each clk. When smp_cnt==period:
//                - shift <= {shift[6:0],BC_s}; bit_cnt++.
//                - bit_cnt becomes 8 -> DONE; else -> WAIT_FALL.
//               A fall seen before the sample point is ignored.
//   DONE      : one cycle.
//                - shift[7:6]==2'b00 -> ID<=shift, ID_vld<=1.
//                - Otherwise frame discarded; ID and ID_vld unchanged.
//               Always -> IDLE.
//  Arithmetic:
//   - bit_cnt is 4 bits.
//   - TMO_MULT*period is computed at PER_W+3 bits; no wrap.
//   - Counters never wrap.
//  ID_vld:
//   - Set in DONE on an accepted frame; cleared by clr_ID_vld.
//   - Set and clear in the same cycle -> set wins.
//   - A new accepted frame while ID_vld=1 overwrites ID; ID_vld stays 1.
//  ID is stable except in the single DONE cycle of an accepted frame.
//  Glitch-free input assumed after synchronization; no debouncing beyond the sync flops.
// TESTING
//  1. mimic period=22'h1000, send station 8'h15
//     -> ID=8'h15, ID_vld=1 within 3 clk after last sample point; busy returns 0.
//  2. Send 8'hC5 (upper bits nonzero)
//     -> ID keeps prior 8'h15; ID_vld unchanged; state returns to IDLE.
//  3. After test 1, pulse clr_ID_vld -> ID_vld=0 next clk.
//     Also pulse clr_ID_vld in the same cycle as DONE of a valid frame -> ID_vld=1.
//  4. Drive start bit plus 3 bits, then hold BC high for 5*period
//     -> abort to IDLE at TMO_MULT*period; ID_vld stays 0.
//     Next full frame 8'h2A decodes correctly.
//  5. Assert rst_n low mid-bit 4 of a frame -> ID=0, ID_vld=0, busy=0.
//     After release, frame 8'h3F -> ID=8'h3F.
//  6. Back-to-back frames 8'h01 then 8'h3E at period=22'h0400, no clr
//     -> ID ends 8'h3E, ID_vld held 1 throughout.

Source files
------------

// File: rtl/barcode_decoder.sv
// Self-clocked barcode receiver: the start bit's low time sets the bit period, and each
// data bit is sampled one period after its falling edge. Accepts 8-bit IDs with ID[7:6]==0.
module barcode_decoder #(
  parameter int PER_W    = 22,
  parameter int TMO_MULT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FALL,
    SAMPLE,
    DONE
  } state_t;

  state_t             state, nxt_state;
  logic               bc_ff1, bc_s, bc_prev;
  logic               fall, rise;
  logic [PER_W-1:0]   per_cnt, nxt_per_cnt;
  logic [PER_W-1:0]   period, nxt_period;
  logic [PER_W-1:0]   smp_cnt, nxt_smp_cnt;
  logic [PER_W+2:0]   tmo_cnt, nxt_tmo_cnt;
  logic [PER_W+2:0]   tmo_lim;
  logic [3:0]         bit_cnt, nxt_bit_cnt;
  logic [7:0]         shift, nxt_shift;
  logic [7:0]         nxt_id;
  logic               nxt_id_vld;

  // Sync chain presets high so reset release never looks like a start-bit fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_ff1  <= 1'b1;
      bc_s    <= 1'b1;
      bc_prev <= 1'b1;
    end else begin
      bc_ff1  <= BC;
      bc_s    <= bc_ff1;
      bc_prev <= bc_s;
    end
  end

  assign fall    = bc_prev & ~bc_s;
  assign rise    = ~bc_prev & bc_s;
  assign tmo_lim = (PER_W+3)'(TMO_MULT) * {3'b000, period};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      per_cnt <= '0;
      period  <= '0;
      smp_cnt <= '0;
      tmo_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      ID      <= '0;
      ID_vld  <= 1'b0;
    end else begin
      state   <= nxt_state;
      per_cnt <= nxt_per_cnt;
      period  <= nxt_period;
      smp_cnt <= nxt_smp_cnt;
      tmo_cnt <= nxt_tmo_cnt;
      bit_cnt <= nxt_bit_cnt;
      shift   <= nxt_shift;
      ID      <= nxt_id;
      ID_vld  <= nxt_id_vld;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_per_cnt = per_cnt;
    nxt_period  = period;
    nxt_smp_cnt = smp_cnt;
    nxt_tmo_cnt = tmo_cnt;
    nxt_bit_cnt = bit_cnt;
    nxt_shift   = shift;
    nxt_id      = ID;
    nxt_id_vld  = ID_vld;
    busy        = (state != IDLE);

    // Clear applied first so a set in DONE overrides it.
    if (clr_ID_vld)
      nxt_id_vld = 1'b0;

    case (state)
      IDLE: begin
        if (fall) begin
          nxt_state   = START;
          nxt_per_cnt = '0;
        end
      end
      START: begin
        if (rise) begin
          nxt_period  = per_cnt;
          nxt_bit_cnt = '0;
          nxt_tmo_cnt = '0;
          nxt_state   = WAIT_FALL;
        end else if (per_cnt == '1) begin
          nxt_state = IDLE;
        end else if (!bc_s) begin
          nxt_per_cnt = per_cnt + PER_W'(1);
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          nxt_state   = SAMPLE;
          nxt_smp_cnt = '0;
          nxt_tmo_cnt = '0;
        end else if (tmo_cnt >= tmo_lim) begin
          nxt_state   = IDLE;
          nxt_tmo_cnt = '0;
        end else begin
          nxt_tmo_cnt = tmo_cnt + (PER_W+3)'(1);
        end
      end
      SAMPLE: begin
        if (smp_cnt == period) begin
          nxt_shift   = {shift[6:0], bc_s};
          nxt_bit_cnt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            nxt_state = DONE;
          end else begin
            nxt_state   = WAIT_FALL;
            nxt_tmo_cnt = '0;
          end
        end else begin
          nxt_smp_cnt = smp_cnt + PER_W'(1);
        end
      end
      DONE: begin
        if (shift[7:6] == 2'b00) begin
          nxt_id     = shift;
          nxt_id_vld = 1'b1;
        end
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_barcode_decoder.sv
// Directed bench for barcode_decoder: drives self-clocked frames and checks ID/ID_vld/busy.
module tb_barcode_decoder;

  logic       clk;
  logic       rst_n;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int per   = 64;

  logic mon_pulse = 1'b0;
  logic mon_hold  = 1'b0;
  int   vld_pulses = 0;
  int   vld_drops  = 0;

  barcode_decoder #(.PER_W(22), .TMO_MULT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (mon_pulse && ID_vld) vld_pulses++;
    if (mon_hold && !ID_vld) vld_drops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    BC = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start();
    BC = 1'b0;
    repeat (per) @(negedge clk);
    BC = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  // 1: short low then high; 0: long low then short high; sample point sits in between.
  task automatic send_bit(input logic b);
    BC = 1'b0;
    repeat (b ? per / 2 : 3 * per / 2) @(negedge clk);
    BC = 1'b1;
    repeat (b ? 3 * per / 2 : per / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_start();
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    idle(8);
  endtask

  initial begin
    rst_n      = 1'b0;
    BC         = 1'b1;
    clr_ID_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_id", 32'(ID), 32'h00);
    check("rst_vld", 32'(ID_vld), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(4);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Station 0x15, with decode latency checked on the final bit
    send_start();
    check("start_busy", 32'(busy), 32'h1);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h15 >> i));
    BC = 1'b0;
    repeat (per / 2) @(negedge clk);
    BC = 1'b1;
    repeat (per / 2 + 5) @(negedge clk);
    check("t1_vld_latency", 32'(ID_vld), 32'h1);
    check("t1_id", 32'(ID), 32'h15);
    repeat (per - 5) @(negedge clk);
    check("t1_busy_done", 32'(busy), 32'h0);

    // Single-cycle clear
    clr_ID_vld = 1'b1;
    @(negedge clk);
    clr_ID_vld = 1'b0;
    check("t3_clr_vld", 32'(ID_vld), 32'h0);
    check("t3_clr_id", 32'(ID), 32'h15);

    // Upper bits nonzero: frame discarded
    send_frame(8'hC5);
    check("t2_id_kept", 32'(ID), 32'h15);
    check("t2_vld_kept", 32'(ID_vld), 32'h0);
    check("t2_idle", 32'(busy), 32'h0);

    // Truncated frame followed by a long high: timeout abort
    send_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    BC = 1'b1;
    repeat (2 * per) @(negedge clk);
    check("t4_waiting", 32'(busy), 32'h1);
    repeat (3 * per) @(negedge clk);
    check("t4_aborted", 32'(busy), 32'h0);
    check("t4_vld", 32'(ID_vld), 32'h0);
    check("t4_id", 32'(ID), 32'h15);
    send_frame(8'h2A);
    check("t4_next_id", 32'(ID), 32'h2A);
    check("t4_next_vld", 32'(ID_vld), 32'h1);

    // Clear held across DONE: set wins for exactly that cycle
    clr_ID_vld = 1'b1;
    @(negedge clk);
    check("t3b_pre_clr", 32'(ID_vld), 32'h0);
    mon_pulse = 1'b1;
    send_frame(8'h0F);
    mon_pulse = 1'b0;
    clr_ID_vld = 1'b0;
    check("t3b_set_wins", 32'(vld_pulses), 32'd1);
    check("t3b_id", 32'(ID), 32'h0F);
    check("t3b_vld_after", 32'(ID_vld), 32'h0);

    // Reset mid bit 4
    send_frame(8'h2A);
    check("t5_pre_vld", 32'(ID_vld), 32'h1);
    send_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    BC = 1'b0;
    repeat (per / 4) @(negedge clk);
    check("t5_busy_mid", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_id", 32'(ID), 32'h00);
    check("t5_rst_vld", 32'(ID_vld), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    BC = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    send_frame(8'h3F);
    check("t5_id", 32'(ID), 32'h3F);
    check("t5_vld", 32'(ID_vld), 32'h1);

    // Back-to-back frames at a shorter period with no clear
    per = 16;
    mon_hold = 1'b1;
    send_frame(8'h01);
    check("t6_first_id", 32'(ID), 32'h01);
    send_frame(8'h3E);
    mon_hold = 1'b0;
    check("t6_id", 32'(ID), 32'h3E);
    check("t6_vld_held", 32'(vld_drops), 32'd0);
    check("t6_idle", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
